// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch pair type and fetch geometry constants.
package fetch_unit_pkg;
  localparam int FETCH_WIDTH = 2;
  localparam logic [31:0] FETCH_STRIDE = 32'd8;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr1;
    logic [31:0] instr2;
  } fetch_pair_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch pairs with push, pop, flush (flush wins) and occupancy count.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_pair_t   din,
  output fetch_pair_t   dout,
  output logic [CW-1:0] count
);
  fetch_pair_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= din;
  end
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: dual-issue instruction fetch front end feeding decode through a fetch queue.
// Optional FETCH_PERF_CNT_EN adds perf_pairs / perf_stall counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr1,
  output logic [31:0] imem_addr2,
  input  logic [31:0] imem_instr1,
  input  logic [31:0] imem_instr2,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr1,
  output logic [31:0] out_instr2
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_pairs,
  output logic [31:0] perf_stall
`endif
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [31:0] SLOT_BYTES = FETCH_STRIDE / FETCH_WIDTH;
  logic [31:0] pc_q, req_pc_q;
  logic req_valid_q, credit, issue, push, pop;
  logic [CW-1:0] fq_count;
  fetch_pair_t head;
  // Credit counts the in-flight request so a response always has a free slot.
  assign credit = (fq_count + CW'(req_valid_q)) < CW'(FQ_DEPTH);
  assign issue = !rst && !redirect_valid && credit;
  assign push = req_valid_q && !redirect_valid && !rst;
  assign pop = out_valid && out_ready;
  assign imem_addr1 = pc_q;
  assign imem_addr2 = pc_q + SLOT_BYTES;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q        <= redirect_pc;
      req_valid_q <= 1'b0;
    end else begin
      req_valid_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + FETCH_STRIDE;
        req_pc_q <= pc_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) assert (fq_count != CW'(FQ_DEPTH));
  end
  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   ('{pc: req_pc_q, instr1: imem_instr1, instr2: imem_instr2}),
    .dout  (head),
    .count (fq_count)
  );
  assign out_valid  = fq_count != '0;
  assign out_pc     = head.pc;
  assign out_instr1 = head.instr1;
  assign out_instr2 = head.instr2;
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_pairs <= '0;
      perf_stall <= '0;
    end else begin
      if (push) perf_pairs <= perf_pairs + 32'd1;
      if (!redirect_valid && !credit) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a queue-level reference model checked every cycle.
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, redir, ready;
  logic [31:0] rpc;
  logic [31:0] a1, a2, i1, i2, o_pc, o_i1, o_i2;
  logic o_valid;
  logic [31:0] wa1, wa2, wi1, wi2, w_pc, w_i1, w_i2;
  logic w_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_pairs, perf_stall, w_pp, w_ps;
`endif
  int checks = 0, errors = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .imem_addr1(a1), .imem_addr2(a2), .imem_instr1(i1), .imem_instr2(i2),
    .redirect_valid(redir), .redirect_pc(rpc), .out_valid(o_valid), .out_ready(ready),
    .out_pc(o_pc), .out_instr1(o_i1), .out_instr2(o_i2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_pairs(perf_pairs), .perf_stall(perf_stall)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .imem_addr1(wa1), .imem_addr2(wa2), .imem_instr1(wi1), .imem_instr2(wi2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .out_valid(w_valid), .out_ready(1'b1),
    .out_pc(w_pc), .out_instr1(w_i1), .out_instr2(w_i2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_pairs(w_pp), .perf_stall(w_ps)
`endif
  );

  always @(posedge clk) begin
    i1  <= word(a1);
    i2  <= word(a2);
    wi1 <= word(wa1);
    wi2 <= word(wa2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch stream as a PC, one optional in-flight pair and a FIFO of pairs.
  typedef struct {logic [31:0] pc, w1, w2;} mpair_t;
  mpair_t mq[$];
  logic [31:0] m_pc, m_ipc, m_pairs, m_stall;
  bit m_inf, started = 0, can;
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_pc = 32'h0; m_inf = 0; m_pairs = 0; m_stall = 0; started = 1;
    end else if (redir) begin
      mq.delete();
      m_pc = rpc; m_inf = 0;
    end else begin
      can = (mq.size() + int'(m_inf)) < 4;
      if (mq.size() > 0 && ready) void'(mq.pop_front());
      if (m_inf) begin
        mq.push_back('{m_ipc, word(m_ipc), word(m_ipc + 32'd4)});
        m_pairs++;
      end
      if (can) begin
        m_inf = 1; m_ipc = m_pc; m_pc += 32'd8;
      end else begin
        m_inf = 0; m_stall++;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_valid", 32'(o_valid), 32'(mq.size() > 0));
      chk("m_addr1", a1, m_pc);
      chk("m_addr2", a2, m_pc + 32'd4);
      if (mq.size() > 0) begin
        chk("m_pc", o_pc, mq[0].pc);
        chk("m_instr1", o_i1, mq[0].w1);
        chk("m_instr2", o_i2, mq[0].w2);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("m_perf_pairs", perf_pairs, m_pairs);
      chk("m_perf_stall", perf_stall, m_stall);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_release(input logic rdy);
    tick();
    rst = 1; ready = rdy; redir = 0;
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1; ready = 1; redir = 0; rpc = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_addr1", a1, 32'h0);
    chk("rst_addr2", a2, 32'h4);
    chk("wrap_rst_addr1", wa1, 32'hFFFF_FFF8);
    chk("wrap_rst_addr2", wa2, 32'hFFFF_FFFC);
    tick();
    rst = 0;
    @(negedge clk);
    chk("c0_valid", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("c1_valid", 32'(o_valid), 32'd0);
    chk("wrap_next_addr1", wa1, 32'h0);
    @(negedge clk);
    chk("c2_valid", 32'(o_valid), 32'd1);
    chk("c2_pc", o_pc, 32'h0);
    chk("c2_i1", o_i1, 32'h1000_0000);
    chk("c2_i2", o_i2, 32'h1000_0001);
    chk("wrap_pc", w_pc, 32'hFFFF_FFF8);
    chk("wrap_i1", w_i1, 32'h4FFF_FFFE);
    @(negedge clk);
    chk("c3_pc", o_pc, 32'h8);
    chk("c3_i1", o_i1, 32'h1000_0002);
    chk("c3_i2", o_i2, 32'h1000_0003);
    chk("wrap_pc2", w_pc, 32'h0);
    // stall with decode blocked, then drain in order
    reset_release(1'b0);
    repeat (9) tick();
    @(negedge clk);
    chk("stall_addr1", a1, 32'h20);
    chk("stall_valid", 32'(o_valid), 32'd1);
    chk("stall_head", o_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_pairs", perf_pairs, 32'd4);
    chk("perf_stall", perf_stall, 32'd5);
`endif
    tick();
    ready = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("drain_valid", 32'(o_valid), 32'd1);
      chk("drain_pc", o_pc, 32'(k * 8));
    end
    // redirect with 3 queued pairs and one request in flight
    reset_release(1'b0);
    repeat (4) tick();
    redir = 1; rpc = 32'h104;
    @(negedge clk);
    chk("redir_pre_valid", 32'(o_valid), 32'd1);
    tick();
    redir = 0;
    @(negedge clk);
    chk("redir_t1_valid", 32'(o_valid), 32'd0);
    chk("redir_t1_addr1", a1, 32'h104);
    @(negedge clk);
    chk("redir_t2_valid", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("redir_t3_valid", 32'(o_valid), 32'd1);
    chk("redir_pc", o_pc, 32'h104);
    chk("redir_i1", o_i1, 32'h1000_0041);
    chk("redir_i2", o_i2, 32'h1000_0042);
    // reset in the cycle the first response arrives
    reset_release(1'b1);
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("rstmid_valid0", 32'(o_valid), 32'd0);
    chk("rstmid_addr1", a1, 32'h0);
    @(negedge clk);
    chk("rstmid_valid1", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("rstmid_valid2", 32'(o_valid), 32'd1);
    chk("rstmid_pc", o_pc, 32'h0);
    // back-to-back redirects: last wins
    tick();
    ready = 0; redir = 1; rpc = 32'h200;
    tick();
    rpc = 32'h300;
    tick();
    redir = 0;
    repeat (3) @(negedge clk);
    chk("b2b_valid", 32'(o_valid), 32'd1);
    chk("b2b_pc", o_pc, 32'h300);
    for (int n = 0; n < 80; n++) begin
      tick();
      ready = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 9) == 0);
      rpc = 32'($urandom_range(0, 1023)) << 2;
    end
    tick();
    redir = 0; ready = 1;
    repeat (6) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
